scrambler_arbiter: RTL and testbench

- Shares one scrambler/checker unit between NREQ requesters.
- Each requester presents six 3-bit symbols, packed into an 18-bit code, together with a request. The block grants requesters round-robin and launches the unit with a one-cycle ready pulse. It waits for the unit's done pulse and returns the 18-bit result to the granted requester with a one-cycle ack.
- A watchdog timeout recovers from a unit that never reports done.

---
 rtl/scrambler_pkg.sv | 15 +
 rtl/scrambler_arbiter_rr_pick.sv | 31 +++
 rtl/scrambler_arbiter.sv | 131 +++++++++++++
 tb/tb_scrambler_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/scrambler_pkg.sv
// Shared constants and FSM encoding for the scrambler/checker arbiter.
package scrambler_pkg;

  localparam int SYM_W  = 3;
  localparam int NSYM   = 6;
  localparam int CODE_W = SYM_W * NSYM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/scrambler_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr,
  output logic [NREQ-1:0] sel_oh,
  output logic [PW-1:0]   sel_idx,
  output logic            any
);

  int unsigned k;

  // Scan upward from rr and keep only the first hit.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      k = (int'(rr) + off) % NREQ;
      if (!any && req[k]) begin
        any       = 1'b1;
        sel_oh[k] = 1'b1;
        sel_idx   = PW'(k);
      end
    end
  end

endmodule

// File: rtl/scrambler_arbiter.sv
// Round-robin sharing of one scrambler/checker unit with a WAIT watchdog.
module scrambler_arbiter
  import scrambler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*CODE_W-1:0] req_code,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   err,
  output logic [CODE_W-1:0]      result,
  output logic                   sc_ready,
  output logic [CODE_W-1:0]      sc_code,
  input  logic                   sc_done,
  input  logic [CODE_W-1:0]      sc_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nx;
  logic [NREQ-1:0]   sel_oh;
  logic [PW-1:0]     sel_idx, cur_idx, rr;
  logic              any;
  logic [CW-1:0]     timer;
  logic              timed_out;
  logic [CODE_W-1:0] res_buf, code_sel;
  logic              err_buf;
  logic              sc_ready_d, err_d;
  logic [NREQ-1:0]   ack_d;
  logic [PW-1:0]     rr_nx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req     (req),
    .rr      (rr),
    .sel_oh  (sel_oh),
    .sel_idx (sel_idx),
    .any     (any)
  );

  assign timed_out = (timer == CW'(TIMEOUT - 1));
  assign rr_nx     = (cur_idx == PW'(NREQ - 1)) ? '0 : cur_idx + 1'b1;

  // Code of the requester being picked this cycle.
  always_comb begin
    code_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++)
      if (sel_oh[k]) code_sel = req_code[k*CODE_W +: CODE_W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; sc_done wins over the watchdog in the same cycle.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = any ? LAUNCH : IDLE;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = (sc_done || timed_out) ? RESP : WAIT;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; outputs are registered so each appears one cycle after its state.
  always_comb begin
    sc_ready_d = (state == LAUNCH);
    ack_d      = (state == RESP) ? gnt : '0;
    err_d      = (state == RESP) && err_buf;
  end

  // Datapath: grant/code latch, watchdog timer, result capture, pointer advance.
  // gnt is reloaded in IDLE, so it stays up through the ack cycle and only then clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      ack      <= '0;
      err      <= 1'b0;
      sc_ready <= 1'b0;
      sc_code  <= '0;
      result   <= '0;
      rr       <= '0;
      cur_idx  <= '0;
      timer    <= '0;
      res_buf  <= '0;
      err_buf  <= 1'b0;
    end else begin
      sc_ready <= sc_ready_d;
      ack      <= ack_d;
      err      <= err_d;
      case (state)
        IDLE: begin
          gnt <= any ? sel_oh : '0;
          if (any) begin
            cur_idx <= sel_idx;
            sc_code <= code_sel;
          end
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (sc_done) begin
            res_buf <= sc_result;
            err_buf <= 1'b0;
          end else if (timed_out) begin
            res_buf <= '0;
            err_buf <= 1'b1;
          end
        end
        RESP: begin
          result <= res_buf;
          rr     <= rr_nx;
        end
        default: begin
          gnt     <= '0;
          sc_code <= '0;
          result  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scrambler_arbiter.sv
// Self-checking bench for scrambler_arbiter with a delayed-response unit model.
module tb_scrambler_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      req = '0;
  logic [71:0]     req_code = '0;
  logic [3:0]      gnt, ack;
  logic            err;
  logic [17:0]     result, sc_code, sc_result = '0;
  logic            sc_ready, sc_done = 1'b0;

  scrambler_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_code(req_code),
    .gnt(gnt), .ack(ack), .err(err), .result(result),
    .sc_ready(sc_ready), .sc_code(sc_code),
    .sc_done(sc_done), .sc_result(sc_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ack;
    logic [17:0] result;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [17:0] base;
    int          lat;
    logic [17:0] res;
    logic [3:0]  gnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Unit model state: latency (-1 = never responds), pending result, spurious pulse.
  int          unit_lat = 3;
  logic [17:0] unit_res = '0;
  int          cnt = 0;
  logic [17:0] pend = '0;
  logic        spur = 1'b0;
  logic [17:0] spur_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] build(input logic [17:0] base);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*18 +: 18] = base ^ 18'(k * 18'o010101);
    return v;
  endfunction

  function automatic int oh2i(input logic [3:0] g);
    int r;
    r = 0;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Unit model: answers lat cycles after seeing sc_ready; reset by the same rst.
  always @(negedge clk) begin
    sc_done = 1'b0;
    if (!rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          sc_done   = 1'b1;
          sc_result = pend;
        end
      end
      if (sc_ready && unit_lat > 0) begin
        cnt  = unit_lat;
        pend = unit_res;
      end
      if (spur) begin
        sc_done   = 1'b1;
        sc_result = spur_val;
        spur      = 1'b0;
      end
    end
  end

  // Scoreboard: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst) begin
      if (ack != 4'b0) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(ack), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack", 32'(ack), 32'(e.ack));
          chk("result", 32'(result), 32'(e.result));
          chk("err", 32'(err), 32'(e.err));
        end
      end else begin
        chk("err_without_ack", 32'(err), 32'h0);
      end
    end
  end

  // One full transaction: grant, launch, then ack at the exact expected cycle.
  task automatic run_txn(input logic [3:0] r, input logic [17:0] base, input int lat,
                         input logic [17:0] res, input logic [3:0] exp_g);
    logic [17:0] exp_code;
    int cyc, exp_cyc;
    bit ok_done;
    exp_t e;
    req      = r;
    req_code = build(base);
    unit_lat = lat;
    unit_res = res;
    exp_code = base ^ 18'(oh2i(exp_g) * 18'o010101);
    ok_done  = (lat >= 1 && lat <= TO - 1);
    exp_cyc  = ok_done ? lat + 3 : TO + 2;
    e.ack    = exp_g;
    e.result = ok_done ? res : 18'h0;
    e.err    = !ok_done;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("ack_width", 32'(ack), 32'h0);
    sb.push_back(e);
    @(negedge clk);
    chk("sc_ready", 32'(sc_ready), 32'h1);
    chk("sc_code", 32'(sc_code), 32'(exp_code));
    cyc = 1;
    while (ack == 4'b0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("sc_ready_pulse", 32'(sc_ready), 32'h0);
    end
    chk("ack_latency", 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'b1111, 18'(i * 37 + 1000), 3, 18'(i * 91 + 7), 4'(4'b0001 << (i % 4))};
    tbl[8]  = '{4'b0001, 18'o123456, 3,  18'o654321, 4'b0001};
    tbl[9]  = '{4'b0100, 18'o111111, -1, 18'o222222, 4'b0100};
    tbl[10] = '{4'b1010, 18'o333333, 2,  18'o444444, 4'b1000};
    tbl[11] = '{4'b0010, 18'o555555, 14, 18'o666666, 4'b0010};
    tbl[12] = '{4'b0011, 18'o707070, 5,  18'o070707, 4'b0001};

    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_sc_ready", 32'(sc_ready), 32'h0);
    chk("rst_sc_code", 32'(sc_code), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++)
      run_txn(tbl[i].req, tbl[i].base, tbl[i].lat, tbl[i].res, tbl[i].gnt);

    // Code latched at grant; req dropped mid-WAIT still gets its ack.
    req      = 4'b0100;
    req_code = build(18'o070707);
    unit_lat = 3;
    unit_res = 18'o121212;
    @(negedge clk);
    chk("rob_gnt", 32'(gnt), 32'h4);
    sb.push_back('{4'b0100, 18'o121212, 1'b0});
    req_code = '1;
    @(negedge clk);
    chk("rob_sc_code_launch", 32'(sc_code), 32'(18'o070707 ^ 18'o020202));
    req = 4'b0000;
    begin
      int c;
      c = 0;
      while (ack == 4'b0 && c < 40) begin
        @(negedge clk);
        c++;
      end
      chk("rob_ack_seen", 32'(ack), 32'h4);
    end
    chk("rob_sc_code_hold", 32'(sc_code), 32'(18'o070707 ^ 18'o020202));
    @(negedge clk);
    chk("rob_gnt_clear", 32'(gnt), 32'h0);

    // Spurious sc_done in IDLE leaves result alone.
    spur_val = 18'o777000;
    spur     = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_result", 32'(result), 32'(18'o121212));
    chk("spur_gnt", 32'(gnt), 32'h0);

    // Asynchronous reset during WAIT of a unit that never answers.
    req      = 4'b1000;
    req_code = build(18'o246246);
    unit_lat = -1;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h8);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_gnt_zero", 32'(gnt), 32'h0);
    chk("mid_ack_zero", 32'(ack), 32'h0);
    chk("mid_sc_code_zero", 32'(sc_code), 32'h0);
    chk("mid_result_zero", 32'(result), 32'h0);
    chk("mid_sc_ready_zero", 32'(sc_ready), 32'h0);
    chk("mid_err_zero", 32'(err), 32'h0);
    sb.delete();
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Pointer was 3 before reset; a cleared pointer picks requester 0 first.
    run_txn(4'b1001, 18'o135135, 2, 18'o531531, 4'b0001);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
